// File: rtl/comp_serial_pkg.sv
// Shared definitions for the serial 2-bit-slice magnitude comparator:
// FSM state encoding and the bit positions of the one-hot result.
package comp_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int Z_EQ = 2;
  localparam int Z_GT = 1;
  localparam int Z_LT = 0;

  // Index counter width for a given number of 2-bit pairs; never below 1.
  function automatic int idx_width(input int npairs);
    return (npairs > 1) ? $clog2(npairs) : 1;
  endfunction

endpackage

// File: rtl/comp2bit.sv
// Combinational 2-bit unsigned comparator producing the one-hot {eq, gt, lt}.
module comp2bit
  import comp_serial_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [2:0] z
);

  always_comb begin
    z       = '0;
    z[Z_EQ] = (a == b);
    z[Z_GT] = (a > b);
    z[Z_LT] = (a < b);
  end

endmodule

// File: rtl/comp_serial.sv
// Serial unsigned comparator: walks the operands one 2-bit pair per cycle,
// MSB pair first, and stops at the first pair that differs.
//
// Handshake: start is a request sampled only in IDLE (busy low); the
// accepting edge latches a and b. done is a one-cycle pulse while busy is
// still high, and z holds its one-hot result until the next accepted start.
module comp_serial
  import comp_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       z
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int IDXW   = idx_width(NPAIRS);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NPAIRS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx;
  logic [1:0]       sa;
  logic [1:0]       sb;
  logic [2:0]       cmp;
  logic             last_pair;
  logic             resolved;

  // Select the pair addressed by idx from the latched operands.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (idx == IDXW'(i)) begin
        sa = a_q[2*i +: 2];
        sb = b_q[2*i +: 2];
      end
    end
  end

  comp2bit u_comp2bit (
    .a (sa),
    .b (sb),
    .z (cmp)
  );

  assign last_pair = (idx == '0);
  assign resolved  = !cmp[Z_EQ] || last_pair;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (resolved) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend on state only, so nothing on a, b or start reaches them.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      z   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            idx <= IDX_TOP;
            z   <= '0;
          end
        end
        RUN: begin
          // An equal LSB pair yields cmp = 100, which is the all-equal result.
          if (resolved) z <= cmp;
          else          idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_serial.sv
// Directed bench for comp_serial: latency, result encoding, start filtering,
// reset abort and back-to-back operation, plus a WIDTH=2 instance.
module tb_comp_serial;
  import comp_serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [2:0] z;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [2:0] z2;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  comp_serial #(.WIDTH(8)) dut (
    .clk (clk), .rst (rst), .start (start), .a (a), .b (b),
    .busy (busy), .done (done), .z (z)
  );

  comp_serial #(.WIDTH(2)) dut2 (
    .clk (clk), .rst (rst), .start (start2), .a (a2), .b (b2),
    .busy (busy2), .done (done2), .z (z2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one comparison on the 8-bit instance and follow it to done.
  // With poke set, a conflicting start is driven during the 2nd RUN cycle.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] exp_z, input int exp_lat, input bit poke);
    int n;
    int busy_cnt;
    bit got;
    logic [2:0] e;
    n = 0; busy_cnt = 0; got = 0;
    exp_q.push_back(exp_z);
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(posedge clk);
    while (n < 30 && !got) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (poke && n == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end
      if (poke && n == 2) start = 1'b0;
      n++;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_z"}, z, e);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_z_held"}, z, e);
  endtask

  initial begin
    int dcnt;
    int bad;
    int last_pos;
    int n;
    bit got;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_z", z, 3'b000);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    run_cmp("eq_a5", 8'hA5, 8'hA5, 3'b100, 5, 1'b0);
    run_cmp("gt_msb", 8'hC0, 8'h40, 3'b010, 2, 1'b0);
    run_cmp("lt_lsb", 8'h12, 8'h13, 3'b001, 5, 1'b0);
    run_cmp("gt_msb2", 8'h80, 8'h40, 3'b010, 2, 1'b0);
    run_cmp("lt_mid", 8'h34, 8'h38, 3'b001, 4, 1'b0);
    run_cmp("eq_zero", 8'h00, 8'h00, 3'b100, 5, 1'b0);
    run_cmp("start_ignored", 8'h12, 8'h13, 3'b001, 5, 1'b1);

    // Abort in the 2nd RUN cycle.
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_in_run", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_busy", busy, 1'b0);
    check("abort_z", z, 3'b000);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_cmp("after_abort", 8'h00, 8'h01, 3'b001, 5, 1'b0);

    // start held high: one comparison every 3 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk);
    dcnt = 0; bad = 0; last_pos = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (z !== 3'b010) bad++;
        if (last_pos < 0 && i != 2) bad++;
        if (last_pos >= 0 && i - last_pos != 3) bad++;
        last_pos = i;
      end
    end
    start = 1'b0;
    check("burst_pulses", dcnt, 7);
    check("burst_bad_pulses", bad, 0);
    repeat (3) @(negedge clk);
    check("burst_settled", busy, 1'b0);

    // WIDTH=2 instance: lt, then equal.
    for (int t = 0; t < 2; t++) begin
      logic [2:0] ez;
      ez = (t == 0) ? 3'b001 : 3'b100;
      @(negedge clk);
      start2 = 1'b1;
      a2 = (t == 0) ? 2'b10 : 2'b01;
      b2 = (t == 0) ? 2'b11 : 2'b01;
      @(posedge clk);
      n = 0; got = 0;
      while (n < 10 && !got) begin
        @(negedge clk);
        if (n == 0) start2 = 1'b0;
        n++;
        if (done2) got = 1;
      end
      check("w2_latency", n, 2);
      check("w2_z", z2, ez);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
